// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin front end that shares one combinational 8-bit ALU
// between two requesters. An accepted operation is registered, driven to the
// ALU for a single execute cycle, and its result is returned with the ID of
// the requester that issued it.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   reqN_valid/_s/_x/_y          requester N operation (select, operands)
//   reqN_ready                   requester N operation accepted this cycle
//   alu_x, alu_y, alu_s          registered operands/select to the ALU
//   alu_z                        combinational ALU result
//   rsp_valid, rsp_id, rsp_z     response channel to the consumer
//   rsp_ready                    consumer takes the response
//   ops_done                     wrapping count of completed responses
//
// All vectors use bit 0 as the MSB.
module alu_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [0:2]  req0_s,
  input  logic [0:7]  req0_x,
  input  logic [0:7]  req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [0:2]  req1_s,
  input  logic [0:7]  req1_x,
  input  logic [0:7]  req1_y,
  output logic        req1_ready,
  output logic [0:7]  alu_x,
  output logic [0:7]  alu_y,
  output logic [0:2]  alu_s,
  input  logic [0:7]  alu_z,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [0:7]  rsp_z,
  input  logic        rsp_ready,
  output logic [0:15] ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [0:7]  alu_x_q, alu_x_d;
  logic [0:7]  alu_y_q, alu_y_d;
  logic [0:2]  alu_s_q, alu_s_d;
  logic [0:7]  rsp_z_q, rsp_z_d;
  logic        rsp_id_q, rsp_id_d;
  logic [0:15] ops_done_q, ops_done_d;

  logic grant_id;
  logic grant_any;

  // Under contention the requester not granted last wins; otherwise the sole
  // requester wins. Ready is suppressed during reset.
  always_comb begin
    grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    grant_any  = (state_q == StIdle) & ~rst & (req0_valid | req1_valid);
    req0_ready = grant_any & ~grant_id;
    req1_ready = grant_any & grant_id;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_s_d      = alu_s_q;
    rsp_z_d      = rsp_z_q;
    rsp_id_d     = rsp_id_q;
    ops_done_d   = ops_done_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          // Operands go straight into the ALU-facing registers so the ALU
          // sees them for the whole execute cycle and never sees request
          // inputs combinationally.
          alu_x_d      = grant_id ? req1_x : req0_x;
          alu_y_d      = grant_id ? req1_y : req0_y;
          alu_s_d      = grant_id ? req1_s : req0_s;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_z_d = alu_z;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_s_q      <= '0;
      rsp_z_q      <= '0;
      rsp_id_q     <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_s_q      <= alu_s_d;
      rsp_z_q      <= rsp_z_d;
      rsp_id_q     <= rsp_id_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_s     = alu_s_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: a transaction-level model runs beside
// the DUT and is compared every cycle, while directed sequences pin literal
// results (ADD, XOR/AND contention, SUB backpressure, reset mid-op, wrap).
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [0:2]  req0_s, req1_s;
  logic [0:7]  req0_x, req0_y, req1_x, req1_y;
  logic        req0_ready, req1_ready;
  logic [0:7]  alu_x, alu_y, alu_z;
  logic [0:2]  alu_s;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [0:7]  rsp_z;
  logic [0:15] ops_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit preload_on = 1'b0;

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_s     (req0_s),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_s     (req1_s),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ready (req1_ready),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_s      (alu_s),
    .alu_z      (alu_z),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_ready  (rsp_ready),
    .ops_done   (ops_done)
  );

  // Reference ALU: stands in for the real ALU instance and serves the model.
  function automatic logic [7:0] alu_ref(input logic [2:0] s, input logic [7:0] x,
                                         input logic [7:0] y);
    case (s)
      3'd0:    return ~x;
      3'd1:    return x | y;
      3'd2:    return x & y;
      3'd3:    return x ^ y;
      3'd4:    return x + y;
      3'd5:    return x - y;
      3'd6:    return (x > y) ? 8'd1 : 8'd0;
      default: return {4'b0, x[3:0]} * {4'b0, y[3:0]};
    endcase
  endfunction

  always_comb alu_z = alu_ref(alu_s, alu_x, alu_y);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation in flight at most; its response is
  // visible from the second cycle after the grant until it is consumed.
  bit         m_seen_rst = 1'b0;
  bit         m_inflight = 1'b0;
  int         m_age = 0;
  bit         m_id = 1'b0;
  bit         m_last = 1'b1;
  logic [7:0] m_z = '0, m_rz = '0, m_ax = '0, m_ay = '0;
  logic [2:0] m_as = '0;
  logic [15:0] m_cnt = '0;

  always @(negedge clk) begin
    bit e_valid, e_r0, e_r1;
    if (preload_on) m_cnt = 16'hFFFF;
    e_valid = m_inflight && (m_age >= 1);
    e_r0 = !rst && !m_inflight && req0_valid && (!req1_valid || m_last);
    e_r1 = !rst && !m_inflight && req1_valid && (!req0_valid || !m_last);
    check("m_req0_ready", {31'b0, req0_ready}, {31'b0, e_r0});
    check("m_req1_ready", {31'b0, req1_ready}, {31'b0, e_r1});
    if (m_seen_rst) begin
      check("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
      check("m_alu_x", {24'b0, alu_x}, {24'b0, m_ax});
      check("m_alu_y", {24'b0, alu_y}, {24'b0, m_ay});
      check("m_alu_s", {29'b0, alu_s}, {29'b0, m_as});
      check("m_ops_done", {16'b0, ops_done}, {16'b0, m_cnt});
      if (e_valid) begin
        check("m_rsp_z", {24'b0, rsp_z}, {24'b0, m_rz});
        check("m_rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
      end
    end
    if (rst) begin
      m_seen_rst = 1'b1;
      m_inflight = 1'b0;
      m_last = 1'b1;
      m_cnt = '0;
      m_ax = '0; m_ay = '0; m_as = '0;
    end else if (e_valid && rsp_ready) begin
      m_cnt = m_cnt + 16'd1;
      m_inflight = 1'b0;
    end else if (m_inflight) begin
      if (m_age == 0) m_rz = m_z;
      if (m_age < 1) m_age++;
    end else if (e_r0 || e_r1) begin
      m_inflight = 1'b1;
      m_age = 0;
      m_id = e_r1;
      m_last = e_r1;
      m_ax = e_r1 ? req1_x : req0_x;
      m_ay = e_r1 ? req1_y : req0_y;
      m_as = e_r1 ? req1_s : req0_s;
      m_z = alu_ref(m_as, m_ax, m_ay);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait (bounded) for its grant, then withdraw it.
  task automatic send(input bit id, input logic [2:0] s, input logic [7:0] x,
                      input logic [7:0] y);
    bit got;
    got = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_s = s; req1_x = x; req1_y = y;
    end else begin
      req0_valid = 1'b1; req0_s = s; req0_x = x; req0_y = y;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
      if (!got) tick();
    end
    check("send_grant", {31'b0, got}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int         rc[4];
  logic       rid[4];
  logic [7:0] rz[4];
  int         k;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_s = '0; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_s = '0; req1_x = '0; req1_y = '0;
    tick();
    // Second reset cycle: a pending request must not see ready.
    req0_valid = 1'b1; req0_s = 3'd4; req0_x = 8'h12; req0_y = 8'h34;
    @(negedge clk);
    check("rst_ready0", {31'b0, req0_ready}, 32'd0);
    check("rst_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_rst_ops_done", {16'b0, ops_done}, 32'd0);
    check("post_rst_alu_x", {24'b0, alu_x}, 32'd0);
    check("post_rst_alu_y", {24'b0, alu_y}, 32'd0);
    check("post_rst_alu_s", {29'b0, alu_s}, 32'd0);
    check("add_ready_first_idle", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("add_exec_no_valid", {31'b0, rsp_valid}, 32'd0);
    check("add_exec_alu_x", {24'b0, alu_x}, 32'h12);
    tick();
    @(negedge clk);
    check("add_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("add_rsp_z", {24'b0, rsp_z}, 32'h46);
    check("add_rsp_id", {31'b0, rsp_id}, 32'd0);
    tick();
    @(negedge clk);
    check("add_ops_done", {16'b0, ops_done}, 32'd1);
    tick();

    // Backpressure with SUB from req1; req0 pokes at the bus meanwhile.
    rsp_ready = 1'b0;
    send(1'b1, 3'd5, 8'h05, 8'h07);
    tick();
    req0_valid = 1'b1; req0_s = 3'd0; req0_x = 8'hAA; req0_y = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_z", {24'b0, rsp_z}, 32'hFE);
      check("bp_rsp_id", {31'b0, rsp_id}, 32'd1);
      check("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
      check("bp_ops_done", {16'b0, ops_done}, 32'd1);
      check("iso_alu_x", {24'b0, alu_x}, 32'h05);
      tick();
      req0_x = ~req0_x;
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'b0, rsp_valid}, 32'd1);
    tick();
    @(negedge clk);
    check("bp_ops_done_after", {16'b0, ops_done}, 32'd2);
    tick();

    // Contention: both hold valid; grants alternate starting with req0.
    req0_valid = 1'b1; req0_s = 3'd3; req0_x = 8'hF0; req0_y = 8'h3C;
    req1_valid = 1'b1; req1_s = 3'd2; req1_x = 8'hF0; req1_y = 8'h3C;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && k < 4) begin
        rc[k] = c; rid[k] = rsp_id; rz[k] = rsp_z; k++;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("cont_count", k, 32'd4);
    for (int i = 0; i < k; i++) begin
      check("cont_id", {31'b0, rid[i]}, i % 2);
      check("cont_z", {24'b0, rz[i]}, (i % 2) ? 32'h30 : 32'hCC);
      check("cont_cycle", rc[i], 2 + 3 * i);
    end

    // Reset in the EXEC cycle of an OR from req0.
    send(1'b0, 3'd1, 8'h0F, 8'h50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("midrst_ops_done", {16'b0, ops_done}, 32'd0);
      tick();
    end
    req0_valid = 1'b1; req0_s = 3'd3; req0_x = 8'hF0; req0_y = 8'h3C;
    req1_valid = 1'b1; req1_s = 3'd2; req1_x = 8'hF0; req1_y = 8'h3C;
    @(negedge clk);
    check("midrst_win0", {31'b0, req0_ready}, 32'd1);
    check("midrst_lose1", {31'b0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_rsp_z", {24'b0, rsp_z}, 32'hCC);
    tick();

    // Counter wrap via a backdoor preload of 0xFFFF.
    force dut.ops_done_q = 16'hFFFF;
    preload_on = 1'b1;
    tick();
    release dut.ops_done_q;
    preload_on = 1'b0;
    @(negedge clk);
    check("wrap_preload", {16'b0, ops_done}, 32'hFFFF);
    tick();
    send(1'b1, 3'd7, 8'h0A, 8'h0B);
    tick();
    @(negedge clk);
    check("mult_rsp_z", {24'b0, rsp_z}, 32'h6E);
    tick();
    @(negedge clk);
    check("wrap_ops_done", {16'b0, ops_done}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
